// File: rtl/aq_hpcp_evtcnt_chan.sv
// ---------------------------------------------------------------------------
// aq_hpcp_evtcnt_chan
//
// One hardware performance-monitor channel: the mhpmeventN register (event
// selector plus OF/MINH/SINH/UINH mode bits) together with its mhpmcounterN.
// The selected event's per-cycle increment is qualified by privilege mode
// and the mcountinhibit bit, staged for one cycle, then added to the counter.
// A carry out of the counter sets the sticky OF bit and, if OF was clear,
// raises a one-cycle overflow interrupt request.
//
// Ports
//   eventx_clk    in   gated channel clock
//   cpurst_b      in   asynchronous active-low reset
//   event_wen     in   write strobe for the event register
//   cnt_wen       in   write strobe for the counter
//   hpcp_wdata    in   CSR write data (64 bits)
//   event_inc     in   per-event increments, event n at slice
//                      [(n-1)*INC_WIDTH +: INC_WIDTH]
//   priv_mode     in   current privilege: 00 U, 01 S, 11 M, 10 reserved
//   cnt_inhibit   in   mcountinhibit bit for this counter
//   eventx_value  out  event register readback
//   cntx_value    out  counter readback, zero-extended to 64 bits
//   cntx_ovf_irq  out  one-cycle overflow interrupt pulse
// ---------------------------------------------------------------------------
module aq_hpcp_evtcnt_chan #(
    parameter int HPMCNT_NUM   = 42,
    parameter int HPMEVT_WIDTH = 6,
    parameter int CNT_WIDTH    = 64,
    parameter int INC_WIDTH    = 2
) (
    input  logic                             eventx_clk,
    input  logic                             cpurst_b,
    input  logic                             event_wen,
    input  logic                             cnt_wen,
    input  logic [63:0]                      hpcp_wdata,
    input  logic [HPMCNT_NUM*INC_WIDTH-1:0]  event_inc,
    input  logic [1:0]                       priv_mode,
    input  logic                             cnt_inhibit,
    output logic [63:0]                      eventx_value,
    output logic [63:0]                      cntx_value,
    output logic                             cntx_ovf_irq
);

    // The adder is wide enough for both operands plus a carry, so that even
    // a counter narrower than the increment wraps modulo 2^CNT_WIDTH.
    localparam int SUM_W = ((CNT_WIDTH > INC_WIDTH) ? CNT_WIDTH : INC_WIDTH) + 1;
    localparam logic [HPMEVT_WIDTH-1:0] EVT_MAX = HPMEVT_WIDTH'(HPMCNT_NUM);

    localparam logic [1:0] PRIV_U = 2'b00;
    localparam logic [1:0] PRIV_S = 2'b01;
    localparam logic [1:0] PRIV_M = 2'b11;

    // ------------------------------------------------------------------
    // Helper functions
    // ------------------------------------------------------------------

    // A written selector is kept only if it is a legal event index and
    // no bits between the selector field and the mode bits are set.
    function automatic logic evt_sel_legal(input logic [63:0] wdata);
        logic hi_zero;
        logic in_range;
        hi_zero  = (wdata[59:HPMEVT_WIDTH] == '0);
        in_range = (wdata[HPMEVT_WIDTH-1:0] <= EVT_MAX);
        return hi_zero & in_range;
    endfunction

    // Privilege filter; the reserved encoding never counts.
    function automatic logic mode_allows(input logic [1:0] priv,
                                         input logic       minh,
                                         input logic       sinh,
                                         input logic       uinh);
        logic ok;
        case (priv)
            PRIV_M:  ok = ~minh;
            PRIV_S:  ok = ~sinh;
            PRIV_U:  ok = ~uinh;
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [HPMEVT_WIDTH-1:0] evt_sel_r;
    logic                    of_r;
    logic                    minh_r;
    logic                    sinh_r;
    logic                    uinh_r;
    logic [INC_WIDTH-1:0]    stage_r;
    logic [CNT_WIDTH-1:0]    cnt_r;
    logic                    irq_r;

    // ------------------------------------------------------------------
    // Combinational datapath
    // ------------------------------------------------------------------
    logic [INC_WIDTH-1:0]    sel_inc_s;
    logic                    mode_ok_s;
    logic                    qual_s;
    logic [INC_WIDTH-1:0]    stage_nxt_s;
    logic [SUM_W-1:0]        sum_s;
    logic                    carry_s;
    logic                    hw_ovf_s;

    // AND-OR mux picking the increment slice of the selected event.
    always_comb begin
        sel_inc_s = '0;
        for (int n = 1; n <= HPMCNT_NUM; n++) begin
            sel_inc_s = sel_inc_s |
                        ({INC_WIDTH{evt_sel_r == HPMEVT_WIDTH'(n)}} &
                         event_inc[(n-1)*INC_WIDTH +: INC_WIDTH]);
        end
    end

    // Qualify the selected increment with selector, inhibit and mode filter.
    always_comb begin
        mode_ok_s   = mode_allows(priv_mode, minh_r, sinh_r, uinh_r);
        qual_s      = (evt_sel_r != '0) & ~cnt_inhibit & mode_ok_s;
        stage_nxt_s = qual_s ? sel_inc_s : '0;
    end

    // Counter adder; any bit above the counter width is the wrap carry.
    // A software counter write discards the pending increment, so no
    // overflow can be raised on that edge.
    always_comb begin
        sum_s    = SUM_W'(cnt_r) + SUM_W'(stage_r);
        carry_s  = |sum_s[SUM_W-1:CNT_WIDTH];
        hw_ovf_s = carry_s & ~cnt_wen;
    end

    // ------------------------------------------------------------------
    // Sequential logic
    // ------------------------------------------------------------------

    // Event selector and inhibit mode bits: software-written only.
    always_ff @(posedge eventx_clk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            evt_sel_r <= '0;
            minh_r    <= 1'b0;
            sinh_r    <= 1'b0;
            uinh_r    <= 1'b0;
        end else if (event_wen) begin
            evt_sel_r <= evt_sel_legal(hpcp_wdata) ? hpcp_wdata[HPMEVT_WIDTH-1:0] : '0;
            minh_r    <= hpcp_wdata[62];
            sinh_r    <= hpcp_wdata[61];
            uinh_r    <= hpcp_wdata[60];
        end else begin
            evt_sel_r <= evt_sel_r;
            minh_r    <= minh_r;
            sinh_r    <= sinh_r;
            uinh_r    <= uinh_r;
        end
    end

    // Sticky overflow flag; a software write on the same edge wins over
    // the hardware set.
    always_ff @(posedge eventx_clk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            of_r <= 1'b0;
        end else if (event_wen) begin
            of_r <= hpcp_wdata[63];
        end else if (hw_ovf_s) begin
            of_r <= 1'b1;
        end else begin
            of_r <= of_r;
        end
    end

    // Stage 1: capture the qualified increment; an event write flushes it.
    always_ff @(posedge eventx_clk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            stage_r <= '0;
        end else if (event_wen) begin
            stage_r <= '0;
        end else begin
            stage_r <= stage_nxt_s;
        end
    end

    // Stage 2: accumulate, or take the software-written value.
    always_ff @(posedge eventx_clk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            cnt_r <= '0;
        end else if (cnt_wen) begin
            cnt_r <= hpcp_wdata[CNT_WIDTH-1:0];
        end else begin
            cnt_r <= sum_s[CNT_WIDTH-1:0];
        end
    end

    // Overflow interrupt: one pulse on the first wrap while OF is clear,
    // suppressed when software rewrites the event register on that edge.
    always_ff @(posedge eventx_clk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            irq_r <= 1'b0;
        end else begin
            irq_r <= hw_ovf_s & ~of_r & ~event_wen;
        end
    end

    // ------------------------------------------------------------------
    // Readbacks
    // ------------------------------------------------------------------

    // Assemble the event register image; unimplemented bits read zero.
    always_comb begin
        eventx_value                     = 64'h0;
        eventx_value[63]                 = of_r;
        eventx_value[62]                 = minh_r;
        eventx_value[61]                 = sinh_r;
        eventx_value[60]                 = uinh_r;
        eventx_value[HPMEVT_WIDTH-1:0]   = evt_sel_r;
    end

    assign cntx_value   = 64'(cnt_r);
    assign cntx_ovf_irq = irq_r;

endmodule

// File: tb/tb_aq_hpcp_evtcnt_chan.sv
// ---------------------------------------------------------------------------
// Directed self-checking bench for aq_hpcp_evtcnt_chan.
// dut    : default parameters (64-bit counter)
// dut_sm : CNT_WIDTH = 8 for the narrow-wrap case
// Inputs change 1 time unit after the rising edge; outputs are checked there.
// ---------------------------------------------------------------------------
module tb_aq_hpcp_evtcnt_chan;

    localparam int NEV  = 42;
    localparam int INCW = 2;

    logic               clk;
    logic               rst_n;

    logic               event_wen;
    logic               cnt_wen;
    logic [63:0]        wdata;
    logic [NEV*INCW-1:0] event_inc;
    logic [1:0]         priv;
    logic               inhibit;
    logic [63:0]        eventx_value;
    logic [63:0]        cntx_value;
    logic               irq;

    logic               s_event_wen;
    logic               s_cnt_wen;
    logic [63:0]        s_wdata;
    logic [NEV*INCW-1:0] s_event_inc;
    logic [1:0]         s_priv;
    logic               s_inhibit;
    logic [63:0]        s_eventx_value;
    logic [63:0]        s_cntx_value;
    logic               s_irq;

    int n_asserts;
    int n_fail;

    aq_hpcp_evtcnt_chan dut (
        .eventx_clk   (clk),
        .cpurst_b     (rst_n),
        .event_wen    (event_wen),
        .cnt_wen      (cnt_wen),
        .hpcp_wdata   (wdata),
        .event_inc    (event_inc),
        .priv_mode    (priv),
        .cnt_inhibit  (inhibit),
        .eventx_value (eventx_value),
        .cntx_value   (cntx_value),
        .cntx_ovf_irq (irq)
    );

    aq_hpcp_evtcnt_chan #(.CNT_WIDTH(8)) dut_sm (
        .eventx_clk   (clk),
        .cpurst_b     (rst_n),
        .event_wen    (s_event_wen),
        .cnt_wen      (s_cnt_wen),
        .hpcp_wdata   (s_wdata),
        .event_inc    (s_event_inc),
        .priv_mode    (s_priv),
        .cnt_inhibit  (s_inhibit),
        .eventx_value (s_eventx_value),
        .cntx_value   (s_cntx_value),
        .cntx_ovf_irq (s_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asserts++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_evt(input logic [63:0] d);
        event_wen = 1'b1;
        wdata     = d;
        tick();
        event_wen = 1'b0;
        wdata     = 64'h0;
    endtask

    task automatic write_cnt(input logic [63:0] d);
        cnt_wen = 1'b1;
        wdata   = d;
        tick();
        cnt_wen = 1'b0;
        wdata   = 64'h0;
    endtask

    task automatic set_slice(input int n, input logic [1:0] v);
        event_inc[(n-1)*INCW +: INCW] = v;
    endtask

    initial begin
        n_asserts   = 0;
        n_fail      = 0;
        rst_n       = 1'b0;
        event_wen   = 1'b0;
        cnt_wen     = 1'b0;
        wdata       = 64'h0;
        event_inc   = '0;
        priv        = 2'b11;
        inhibit     = 1'b0;
        s_event_wen = 1'b0;
        s_cnt_wen   = 1'b0;
        s_wdata     = 64'h0;
        s_event_inc = '0;
        s_priv      = 2'b11;
        s_inhibit   = 1'b0;

        // Reset state
        tick();
        check_val("rst_eventx", eventx_value, 64'h0);
        check_val("rst_cnt", cntx_value, 64'h0);
        check_val("rst_irq", {63'h0, irq}, 64'h0);
        #4 rst_n = 1'b1;
        tick();

        // Event register writes and selector legality
        write_evt(64'h0000_0000_0000_0005);
        check_val("evt_5", eventx_value, 64'h5);
        write_evt(64'h0000_0000_0000_002B);
        check_val("evt_43_illegal", eventx_value, 64'h0);
        write_evt(64'h0000_0000_0000_002A);
        check_val("evt_42_max", eventx_value, 64'h2A);
        write_evt(64'h0000_0000_0000_0040);
        check_val("evt_hibit_illegal", eventx_value, 64'h0);
        write_evt(64'hF000_0000_0000_0001);
        check_val("evt_modebits", eventx_value, 64'hF000_0000_0000_0001);

        // Basic counting on event 5 in M mode; every other slice busy
        write_evt(64'h5);
        event_inc = '1;
        set_slice(5, 2'd0);
        tick();
        tick();
        check_val("other_slices_idle", cntx_value, 64'd0);
        set_slice(5, 2'd3);
        tick();
        check_val("cnt_lat1", cntx_value, 64'd0);
        tick();
        check_val("cnt_3", cntx_value, 64'd3);
        tick();
        check_val("cnt_6", cntx_value, 64'd6);
        tick();
        check_val("cnt_9", cntx_value, 64'd9);
        set_slice(5, 2'd0);
        tick();
        check_val("cnt_12", cntx_value, 64'd12);
        tick();
        check_val("cnt_hold_12", cntx_value, 64'd12);
        check_val("no_irq_count", {63'h0, irq}, 64'h0);

        // Mode filter: MINH set
        write_evt(64'h4000_0000_0000_0005);
        set_slice(5, 2'd1);
        tick();
        tick();
        tick();
        check_val("minh_blocks", cntx_value, 64'd12);
        priv = 2'b00;
        tick();
        tick();
        check_val("umode_13", cntx_value, 64'd13);
        tick();
        check_val("umode_14", cntx_value, 64'd14);
        priv = 2'b10;
        tick();
        tick();
        check_val("reserved_mode", cntx_value, 64'd15);
        priv    = 2'b00;
        inhibit = 1'b1;
        tick();
        tick();
        check_val("inhibit", cntx_value, 64'd15);
        priv    = 2'b01;
        inhibit = 1'b0;
        tick();
        tick();
        check_val("smode_16", cntx_value, 64'd16);
        set_slice(5, 2'd0);
        priv = 2'b11;
        tick();
        tick();
        check_val("smode_tail_17", cntx_value, 64'd17);

        // Overflow: first wrap pulses
        write_evt(64'h5);
        write_cnt(64'hFFFF_FFFF_FFFF_FFFE);
        set_slice(5, 2'd3);
        tick();
        set_slice(5, 2'd0);
        check_val("pre_wrap_cnt", cntx_value, 64'hFFFF_FFFF_FFFF_FFFE);
        check_val("pre_wrap_irq", {63'h0, irq}, 64'h0);
        tick();
        check_val("wrap1_cnt", cntx_value, 64'd1);
        check_val("wrap1_irq", {63'h0, irq}, 64'h1);
        check_val("wrap1_of", eventx_value, 64'h8000_0000_0000_0005);
        tick();
        check_val("wrap1_irq_one_cycle", {63'h0, irq}, 64'h0);

        // Second wrap with OF already set: no pulse
        write_cnt(64'hFFFF_FFFF_FFFF_FFFE);
        set_slice(5, 2'd3);
        tick();
        set_slice(5, 2'd0);
        tick();
        check_val("wrap2_cnt", cntx_value, 64'd1);
        check_val("wrap2_no_irq", {63'h0, irq}, 64'h0);
        check_val("wrap2_of_sticky", eventx_value, 64'h8000_0000_0000_0005);

        // Clear OF, wrap again: pulse returns
        write_evt(64'h5);
        check_val("of_cleared", eventx_value, 64'h5);
        write_cnt(64'hFFFF_FFFF_FFFF_FFFE);
        set_slice(5, 2'd3);
        tick();
        set_slice(5, 2'd0);
        tick();
        check_val("wrap3_irq", {63'h0, irq}, 64'h1);
        check_val("wrap3_of", eventx_value, 64'h8000_0000_0000_0005);
        tick();
        check_val("wrap3_irq_low", {63'h0, irq}, 64'h0);

        // Counter write discards the pending increment
        write_evt(64'h5);
        set_slice(5, 2'd2);
        tick();
        set_slice(5, 2'd0);
        write_cnt(64'd100);
        check_val("cntwr_discard", cntx_value, 64'd100);
        tick();
        check_val("cntwr_discard_hold", cntx_value, 64'd100);

        // Stage 1 still captures on a counter-write edge
        set_slice(5, 2'd1);
        write_cnt(64'd200);
        set_slice(5, 2'd0);
        check_val("cntwr_200", cntx_value, 64'd200);
        tick();
        check_val("cntwr_stage_kept", cntx_value, 64'd201);

        // Event write clearing OF on the wrap edge: software wins, no pulse
        write_cnt(64'hFFFF_FFFF_FFFF_FFFF);
        set_slice(5, 2'd1);
        tick();
        set_slice(5, 2'd0);
        write_evt(64'h5);
        check_val("evtwr_wrap_cnt", cntx_value, 64'd0);
        check_val("evtwr_wrap_of", eventx_value, 64'h5);
        check_val("evtwr_wrap_irq", {63'h0, irq}, 64'h0);
        tick();
        check_val("evtwr_wrap_irq_next", {63'h0, irq}, 64'h0);

        // Keep the main channel counting during the narrow-counter case
        write_cnt(64'h1234);
        set_slice(5, 2'd3);
        tick();
        tick();
        check_val("busy_cnt", cntx_value, 64'h1237);

        // 8-bit counter: 0xFE + 3 wraps to 0x01
        s_event_wen = 1'b1;
        s_wdata     = 64'h5;
        tick();
        s_event_wen = 1'b0;
        s_cnt_wen   = 1'b1;
        s_wdata     = 64'hFFFF_FF00_0000_00FE;
        tick();
        s_cnt_wen   = 1'b0;
        s_wdata     = 64'h0;
        check_val("sm_cnt_fe", s_cntx_value, 64'hFE);
        s_event_inc[(5-1)*INCW +: INCW] = 2'd3;
        tick();
        s_event_inc = '0;
        tick();
        check_val("sm_wrap_cnt", s_cntx_value, 64'h1);
        check_val("sm_wrap_of", s_eventx_value, 64'h8000_0000_0000_0005);
        check_val("sm_wrap_irq", {63'h0, s_irq}, 64'h1);

        // Asynchronous reset between edges, while the irq is high
        #2 rst_n = 1'b0;
        #1;
        check_val("arst_eventx", eventx_value, 64'h0);
        check_val("arst_cnt", cntx_value, 64'h0);
        check_val("arst_irq", {63'h0, irq}, 64'h0);
        check_val("arst_sm_eventx", s_eventx_value, 64'h0);
        check_val("arst_sm_cnt", s_cntx_value, 64'h0);
        check_val("arst_sm_irq", {63'h0, s_irq}, 64'h0);
        tick();
        check_val("arst_hold_cnt", cntx_value, 64'h0);
        #4 rst_n = 1'b1;
        tick();
        tick();
        check_val("post_rst_cnt", cntx_value, 64'h0);
        check_val("post_rst_eventx", eventx_value, 64'h0);
        check_val("post_rst_irq", {63'h0, irq}, 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
